mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that acts as a responder on the CPU data bus (ce/we/addr/data_i/data_o), alongside the data memory. Software writes bytes to a TXDATA register. Bytes queue in a FIFO and are serialized 8N1, LSB first, on `tx`. Status, baud divisor and interrupt enable are readable and writable over the same bus. No wait states.

Parameters:
BASE_ADDR, 32'h1000_0000, base of the 16-byte register window; low 4 bits are zero.
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
DEFAULT_DIV, 16'd9, reset value of DIVISOR; bit time is DIVISOR+1 clk cycles.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
ce  in  1  data bus chip enable from CPU
we  in  1  write enable (1 = write, 0 = read), qualified by ce
addr  in  32  byte address from CPU
data_i  in  32  write data from CPU
data_o  out  32  read data to CPU
tx  out  1  serial output, idle high
irq  out  1  level interrupt: transmitter drained

Behaviour:
- Hit: `ce && addr[31:4]==BASE_ADDR[31:4]`. Register select is `addr[3:2]`; `addr[1:0]` is ignored.
- Writes take effect on the rising edge when hit && we. Reads are combinational.
- `data_o` = selected register when hit && !we, else 32'h0.
- Register map:
  - 0x0 TXDATA (write): push `data_i[7:0]`. Reads return 0.
  - 0x4 STATUS (read):
    - [0] busy (FSM not IDLE)
    - [1] fifo_empty
    - [2] fifo_full
    - [3] overflow (sticky)
    - [7:4] fifo count
    - others 0
  - 0x4 STATUS (write): writing 1 to bit 3 clears overflow; other bits are ignored.
  - 0x8 DIVISOR: R/W `[15:0]`; `[31:16]` read 0.
  - 0xC CTRL: R/W `[0]` irq_en; other bits read 0.
- Reset (rst=0, async) state and outputs:
  - tx=1, irq=0, data_o follows its combinational rule (0 with ce=0)
  - FIFO empty, count 0
  - overflow=0, DIVISOR=DEFAULT_DIV, irq_en=0
  - FSM=IDLE, bit counters 0
  - Reset mid-frame aborts the frame immediately; tx returns high.
- FIFO push rules:
  - A push is accepted if count<FIFO_DEPTH, or if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - A simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty → pop the head into the shift register, latch DIVISOR into div_q, go to START, tx=0.
  - START: hold tx=0 for div_q+1 cycles → DATA, tx=shift[0].
  - DATA: each bit is held div_q+1 cycles, LSB first. After bit 7 → STOP, tx=1.
  - STOP: hold tx=1 for div_q+1 cycles → IDLE.
  - IDLE pops on the next edge if the FIFO is non-empty, so back-to-back frames have no extra idle gap beyond that one cycle.
- Latency: a TXDATA write at edge E into an empty FIFO with FSM idle drives tx low from edge E+1.
- Frame length: 10*(div_q+1) cycles, plus 1 IDLE cycle between frames.
- DIVISOR writes affect only frames started afterwards. DIVISOR=0 gives a 1-cycle bit time.
- irq = irq_en && fifo_empty && FSM==IDLE, registered (updates one edge after the condition changes).

Test Plan:
1. Reset (rst=0, then 1) → tx=1, irq=0. Read 0x4 gives 32'h0000_0002; read 0x8 gives 9; read 0xC gives 0.
2. Write 0x55 to TXDATA at edge E → tx low from E+1 for 10 cycles. Then bits 1,0,1,0,1,0,1,0, 10 cycles each. Then stop high for 10 cycles. busy=1 throughout and 0 after.
3. Write DIVISOR=3 and CTRL=1, then 9 TXDATA writes on consecutive cycles (0x00..0x08) → ninth accepted (first already popped). STATUS after 9 writes reads count 8, full=1, overflow=0. A tenth write sets overflow=1. Only 9 frames of 40 cycles each are emitted, separated by 1-cycle gaps.
4. Write STATUS=0x8 → overflow clears. irq rises one edge after the last stop bit ends with the FIFO empty; it stays low with CTRL=0.
5. Assert rst mid-DATA of frame 0xA3 → tx=1 immediately, FIFO empty, STATUS=0x2, no further frames.
6. Access at BASE_ADDR+0x20 or with ce=0 → data_o=0, no register change. Read of TXDATA → 0.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU data-bus signals shared between the CPU (master) and a memory-mapped responder (slave).
interface mmio_uart_tx_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  modport master (output ce, we, addr, data_i, input data_o);
  modport slave (input ce, we, addr, data_i, output data_o);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO, status/divisor/ctrl registers and a drain interrupt.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd9
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   divisor_q, div_q, cnt_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_q;
  logic          ovf_q, irq_en_q, tx_q, irq_q;
  logic          hit, wr, pop, push_req, push, empty, full, busy, tick;
  logic [1:0]    sel;
  logic          unused_bits;
  assign hit         = bus.ce && bus.addr[31:4] == BASE_ADDR[31:4];
  assign sel         = bus.addr[3:2];
  assign wr          = hit && bus.we;
  assign empty       = count_q == '0;
  assign full        = count_q == (AW+1)'(FIFO_DEPTH);
  assign busy        = state_q != IDLE;
  assign pop         = !busy && !empty;
  assign push_req    = wr && sel == 2'd0;
  assign push        = push_req && (!full || pop);
  assign tick        = cnt_q == div_q;
  assign count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign tx          = tx_q;
  assign irq         = irq_q;
  assign unused_bits = ^{bus.addr[1:0], bus.data_i[31:16]};
  always_comb
    bus.data_o = !(hit && !bus.we) ? 32'h0 :
                 sel == 2'd1 ? {24'h0, 4'(count_q), ovf_q, full, empty, busy} :
                 sel == 2'd2 ? {16'h0, divisor_q} :
                 sel == 2'd3 ? {31'h0, irq_en_q} : 32'h0;
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= bus.data_i[7:0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      divisor_q <= DEFAULT_DIV;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      if (push_req && !push) ovf_q <= 1'b1;
      else if (wr && sel == 2'd1 && bus.data_i[3]) ovf_q <= 1'b0;
      if (wr && sel == 2'd2) divisor_q <= bus.data_i[15:0];
      if (wr && sel == 2'd3) irq_en_q <= bus.data_i[0];
      irq_q <= irq_en_q && empty && !busy;
    end
  // tx is registered here so a reset mid-frame forces the line idle at once
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            div_q   <= divisor_q;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        START:
          if (tick) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else cnt_q <= cnt_q + 16'd1;
        DATA:
          if (tick) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else cnt_q <= cnt_q + 16'd1;
        STOP:
          if (tick) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else cnt_q <= cnt_q + 16'd1;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed checks of reset, framing, FIFO overflow, irq, mid-frame reset and address decode.
module tb_mmio_uart_tx;
  localparam logic [31:0] A = 32'h1000_0000;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx, irq, e;
  logic [31:0] rd_v;
  logic [7:0]  bv;
  int          checks = 0, failures = 0, k, p;
  mmio_uart_tx_if bus();
  mmio_uart_tx dut (.clk(clk), .rst(rst), .bus(bus), .tx(tx), .irq(irq));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = d;
    @(posedge clk); #1;
    bus.ce = 1'b0; bus.we = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1 d = bus.data_o;
    bus.ce = 1'b0;
  endtask
  initial begin
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_i = '0;
    repeat (2) @(posedge clk);
    #1 chk("rst_tx", tx, 1);
    chk("rst_irq", irq, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rd(A + 4, rd_v);  chk("status_rst", rd_v, 32'h2);
    rd(A + 8, rd_v);  chk("div_rst", rd_v, 32'd9);
    rd(A + 12, rd_v); chk("ctrl_rst", rd_v, 32'h0);
    wr(A, 32'h55);
    chk("latency_tx", tx, 1);
    bv = 8'h55;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      k = c / 10;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bv[k-1];
      chk("frame55_tx", tx, e);
      rd(A + 4, rd_v);
      chk("frame55_busy", rd_v[0], 1);
    end
    @(posedge clk); #1;
    chk("after55_tx", tx, 1);
    rd(A + 4, rd_v); chk("after55_status", rd_v, 32'h2);
    wr(A + 8, 32'd3);
    wr(A + 12, 32'd1);
    for (int i = 0; i < 9; i++) wr(A, i);
    rd(A + 4, rd_v); chk("full_status", rd_v, 32'h85);
    wr(A, 32'hEE);
    rd(A + 4, rd_v); chk("ovf_status", rd_v, 32'h8D);
    wr(A + 4, 32'h8);
    rd(A + 4, rd_v); chk("ovf_clear", rd_v, 32'h85);
    for (int o = 10; o <= 370; o++) begin
      @(posedge clk); #1;
      k = o / 41;
      p = o % 41;
      bv = 8'(k);
      e = (k > 8 || p >= 36) ? 1'b1 : (p < 4) ? 1'b0 : bv[(p-4)/4];
      chk("burst_tx", tx, e);
      chk("burst_irq", irq, o >= 369);
    end
    wr(A + 12, 32'd0);
    chk("irq_hold", irq, 1);
    @(posedge clk); #1;
    chk("irq_off", irq, 0);
    @(posedge clk); #1;
    chk("irq_stays_off", irq, 0);
    wr(A, 32'hA3);
    wr(A, 32'h5A);
    repeat (12) @(posedge clk);
    #1 chk("mid_data_tx", tx, 0);
    rd(A + 4, rd_v); chk("mid_status", rd_v, 32'h11);
    rst = 1'b0;
    #1 chk("async_rst_tx", tx, 1);
    chk("async_rst_irq", irq, 0);
    rst = 1'b1;
    rd(A + 4, rd_v); chk("post_rst_status", rd_v, 32'h2);
    rd(A + 8, rd_v); chk("post_rst_div", rd_v, 32'd9);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", tx, 1);
    end
    wr(A + 32'h28, 32'd5);
    rd(A + 8, rd_v);     chk("miss_no_write", rd_v, 32'd9);
    rd(A + 32'h24, rd_v); chk("miss_read", rd_v, 32'h0);
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = A + 8;
    #1 chk("ce0_read", bus.data_o, 32'h0);
    bus.we = 1'b1; bus.addr = A; bus.data_i = 32'h77;
    @(posedge clk); #1;
    bus.we = 1'b0;
    rd(A + 4, rd_v); chk("ce0_no_push", rd_v, 32'h2);
    @(posedge clk); #1;
    chk("ce0_tx_idle", tx, 1);
    rd(A, rd_v); chk("txdata_read", rd_v, 32'h0);
    wr(A + 8, 32'd0);
    wr(A, 32'h01);
    bv = 8'h01;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      e = (c == 0) ? 1'b0 : (c == 9) ? 1'b1 : bv[c-1];
      chk("div0_tx", tx, e);
    end
    @(posedge clk); #1;
    rd(A + 4, rd_v); chk("div0_done", rd_v, 32'h2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
